// File: rtl/fpga_io_pkg.sv
// fpga_io_pkg: shared constants for the memory-mapped I/O port.
package fpga_io_pkg;
    localparam int WORD_W = 16;
    localparam logic [1:0] ADDR_IN_DATA  = 2'd0;
    localparam logic [1:0] ADDR_OUT_DATA = 2'd1;
    localparam logic [1:0] ADDR_STATUS   = 2'd2;
    localparam logic [1:0] ADDR_IN_COUNT = 2'd3;
    localparam int ST_IN_AVAIL  = 0;
    localparam int ST_OUT_FULL  = 1;
    localparam int ST_UNDERFLOW = 2;
    localparam int ST_OVERFLOW  = 3;
endpackage

// File: rtl/io_fifo.sv
// io_fifo: inbound word buffer; push ignored when full, pop ignored when empty.
module io_fifo
    import fpga_io_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [WORD_W-1:0] data_i,
    output logic [WORD_W-1:0] data_o,
    output logic [AW:0]       count_o,
    output logic              full_o,
    output logic              empty_o
);
    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q;
    logic              do_push, do_pop;

    assign full_o  = count_q == (AW+1)'(DEPTH);
    assign empty_o = count_q == '0;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end
endmodule

// File: rtl/fpga_io_port.sv
// fpga_io_port: CPU-facing I/O registers bridging to inbound/outbound valid-ready streams.
module fpga_io_port
    import fpga_io_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [1:0]        IOAddr,
    input  logic              IORead,
    input  logic              IOWrite,
    input  logic [WORD_W-1:0] IOWrData,
    output logic [WORD_W-1:0] IORdData,
    input  logic [WORD_W-1:0] ExtInData,
    input  logic              ExtInValid,
    output logic              ExtInReady,
    output logic [WORD_W-1:0] ExtOutData,
    output logic              ExtOutValid,
    input  logic              ExtOutReady
);
    localparam int AW = $clog2(DEPTH);

    logic [WORD_W-1:0] fifo_data, status, rd_mux;
    logic [AW:0]       count;
    logic              full, empty;
    logic              rd_in, wr_out, wr_st, hs, out_acc;
    logic [WORD_W-1:0] rdata_q, rdata_d, out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d, udf_q, udf_d, ovf_q, ovf_d;

    io_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (CLK),
        .rst     (reset),
        .push_i  (ExtInValid),
        .pop_i   (rd_in),
        .data_i  (ExtInData),
        .data_o  (fifo_data),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    assign rd_in  = IORead && IOAddr == ADDR_IN_DATA;
    assign wr_out = IOWrite && IOAddr == ADDR_OUT_DATA;
    assign wr_st  = IOWrite && IOAddr == ADDR_STATUS;
    assign hs     = out_valid_q && ExtOutReady;

    always_comb begin
        status               = '0;
        status[ST_IN_AVAIL]  = !empty;
        status[ST_OUT_FULL]  = out_valid_q;
        status[ST_UNDERFLOW] = udf_q;
        status[ST_OVERFLOW]  = ovf_q;
        rd_mux = IOAddr == ADDR_IN_DATA  ? (empty ? '0 : fifo_data) :
                 IOAddr == ADDR_OUT_DATA ? out_data_q :
                 IOAddr == ADDR_STATUS   ? status : WORD_W'(count);
        rdata_d = IORead ? rd_mux : rdata_q;
        // A write landing on the handshake edge refills the buffer instead of overflowing.
        out_acc     = wr_out && (!out_valid_q || hs);
        out_data_d  = out_acc ? IOWrData : out_data_q;
        out_valid_d = out_acc || (out_valid_q && !hs);
        udf_d = (udf_q && !(wr_st && IOWrData[ST_UNDERFLOW])) || (rd_in && empty);
        ovf_d = (ovf_q && !(wr_st && IOWrData[ST_OVERFLOW])) || (wr_out && out_valid_q && !ExtOutReady);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            rdata_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            udf_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            rdata_q     <= rdata_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            udf_q       <= udf_d;
            ovf_q       <= ovf_d;
        end
    end

    assign IORdData    = rdata_q;
    assign ExtInReady  = !full;
    assign ExtOutData  = out_data_q;
    assign ExtOutValid = out_valid_q;
endmodule

// File: tb/tb_fpga_io_port.sv
// tb_fpga_io_port: directed vector table plus randomized run against a queue-based model.
module tb_fpga_io_port;
    import fpga_io_pkg::*;
    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        reset, IORead, IOWrite, ExtInValid, ExtOutReady;
    logic [1:0]  IOAddr;
    logic [15:0] IOWrData, ExtInData;
    logic [15:0] IORdData, ExtOutData;
    logic        ExtInReady, ExtOutValid;

    always #5 CLK = ~CLK;

    fpga_io_port #(.DEPTH(DEPTH)) dut (
        .CLK         (CLK),
        .reset       (reset),
        .IOAddr      (IOAddr),
        .IORead      (IORead),
        .IOWrite     (IOWrite),
        .IOWrData    (IOWrData),
        .IORdData    (IORdData),
        .ExtInData   (ExtInData),
        .ExtInValid  (ExtInValid),
        .ExtInReady  (ExtInReady),
        .ExtOutData  (ExtOutData),
        .ExtOutValid (ExtOutValid),
        .ExtOutReady (ExtOutReady)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic [1:0]  addr;
        logic        rd, wr;
        logic [15:0] wd;
        logic        iv;
        logic [15:0] id;
        logic        ordy;
        logic [15:0] e_rd;
        logic        e_ir, e_ov;
        logic [15:0] e_od;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t v(input logic rst, input logic [1:0] addr, input logic rd, wr,
                               input logic [15:0] wd, input logic iv, input logic [15:0] id,
                               input logic ordy, input logic [15:0] e_rd, input logic e_ir, e_ov,
                               input logic [15:0] e_od);
        vec_t r;
        r.rst = rst; r.addr = addr; r.rd = rd; r.wr = wr; r.wd = wd; r.iv = iv; r.id = id;
        r.ordy = ordy; r.e_rd = e_rd; r.e_ir = e_ir; r.e_ov = e_ov; r.e_od = e_od;
        return r;
    endfunction

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step(input logic rst, input logic [1:0] addr, input logic rd, wr,
                        input logic [15:0] wd, input logic iv, input logic [15:0] id, input logic ordy);
        reset = rst; IOAddr = addr; IORead = rd; IOWrite = wr; IOWrData = wd;
        ExtInValid = iv; ExtInData = id; ExtOutReady = ordy;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [15:0] mq[$];
        logic [15:0] m_rd, m_od, wd, id;
        logic        m_ov, m_udf, m_ovf, r, rd, wr, iv, ordy, ir;
        logic [1:0]  a;
        step(1, 0, 0, 0, 0, 0, 0, 0);
        // rst addr rd wr wd iv id ordy | rdata in_rdy out_v out_d
        tv.push_back(v(1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000));
        tv.push_back(v(0, 2, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000));
        tv.push_back(v(0, 0, 0, 0, 16'h0000, 1, 16'h1234, 0, 16'h0000, 1, 0, 16'h0000));
        tv.push_back(v(0, 0, 0, 0, 16'h0000, 1, 16'hBEEF, 0, 16'h0000, 1, 0, 16'h0000));
        tv.push_back(v(0, 3, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0002, 1, 0, 16'h0000));
        tv.push_back(v(0, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h1234, 1, 0, 16'h0000));
        tv.push_back(v(0, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'hBEEF, 1, 0, 16'h0000));
        tv.push_back(v(0, 2, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000));
        tv.push_back(v(0, 0, 0, 0, 16'h0000, 1, 16'hA001, 0, 16'h0000, 1, 0, 16'h0000));
        tv.push_back(v(0, 0, 0, 0, 16'h0000, 1, 16'hA002, 0, 16'h0000, 1, 0, 16'h0000));
        tv.push_back(v(0, 0, 0, 0, 16'h0000, 1, 16'hA003, 0, 16'h0000, 1, 0, 16'h0000));
        tv.push_back(v(0, 0, 0, 0, 16'h0000, 1, 16'hA004, 0, 16'h0000, 0, 0, 16'h0000));
        tv.push_back(v(0, 0, 0, 0, 16'h0000, 1, 16'hA005, 0, 16'h0000, 0, 0, 16'h0000));
        tv.push_back(v(0, 0, 1, 0, 16'h0000, 1, 16'hA005, 0, 16'hA001, 1, 0, 16'h0000));
        tv.push_back(v(0, 0, 0, 0, 16'h0000, 1, 16'hA005, 0, 16'hA001, 0, 0, 16'h0000));
        tv.push_back(v(0, 3, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0004, 0, 0, 16'h0000));
        tv.push_back(v(0, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'hA002, 1, 0, 16'h0000));
        tv.push_back(v(0, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'hA003, 1, 0, 16'h0000));
        tv.push_back(v(0, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'hA004, 1, 0, 16'h0000));
        tv.push_back(v(0, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'hA005, 1, 0, 16'h0000));
        tv.push_back(v(0, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000));
        tv.push_back(v(0, 2, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0004, 1, 0, 16'h0000));
        tv.push_back(v(0, 2, 0, 1, 16'h0004, 0, 16'h0000, 0, 16'h0004, 1, 0, 16'h0000));
        tv.push_back(v(0, 1, 0, 1, 16'h00AA, 0, 16'h0000, 0, 16'h0004, 1, 1, 16'h00AA));
        tv.push_back(v(0, 1, 0, 1, 16'h00BB, 0, 16'h0000, 0, 16'h0004, 1, 1, 16'h00AA));
        tv.push_back(v(0, 2, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h000A, 1, 1, 16'h00AA));
        tv.push_back(v(0, 2, 0, 1, 16'h0008, 0, 16'h0000, 0, 16'h000A, 1, 1, 16'h00AA));
        tv.push_back(v(0, 2, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0002, 1, 1, 16'h00AA));
        tv.push_back(v(0, 1, 0, 1, 16'h00CC, 0, 16'h0000, 1, 16'h0002, 1, 1, 16'h00CC));
        tv.push_back(v(0, 2, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0002, 1, 1, 16'h00CC));
        tv.push_back(v(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0002, 1, 0, 16'h00CC));
        tv.push_back(v(0, 1, 0, 1, 16'h00DD, 0, 16'h0000, 0, 16'h0002, 1, 1, 16'h00DD));
        tv.push_back(v(0, 0, 0, 0, 16'h0000, 1, 16'hC001, 0, 16'h0002, 1, 1, 16'h00DD));
        tv.push_back(v(0, 0, 0, 0, 16'h0000, 1, 16'hC002, 0, 16'h0002, 1, 1, 16'h00DD));
        tv.push_back(v(0, 0, 0, 0, 16'h0000, 1, 16'hC003, 0, 16'h0002, 1, 1, 16'h00DD));
        tv.push_back(v(1, 0, 1, 1, 16'hFFFF, 1, 16'hC004, 0, 16'h0000, 1, 0, 16'h0000));
        tv.push_back(v(0, 3, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000));
        tv.push_back(v(0, 0, 1, 0, 16'h0000, 1, 16'hE001, 0, 16'h0000, 1, 0, 16'h0000));
        tv.push_back(v(0, 2, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0005, 1, 0, 16'h0000));
        tv.push_back(v(0, 3, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0001, 1, 0, 16'h0000));
        tv.push_back(v(0, 2, 0, 1, 16'h0004, 0, 16'h0000, 0, 16'h0001, 1, 0, 16'h0000));
        tv.push_back(v(0, 0, 1, 0, 16'h0000, 1, 16'hE002, 0, 16'hE001, 1, 0, 16'h0000));
        tv.push_back(v(0, 3, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0001, 1, 0, 16'h0000));
        tv.push_back(v(0, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'hE002, 1, 0, 16'h0000));
        tv.push_back(v(0, 2, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000));
        foreach (tv[k]) begin
            step(tv[k].rst, tv[k].addr, tv[k].rd, tv[k].wr, tv[k].wd, tv[k].iv, tv[k].id, tv[k].ordy);
            chk($sformatf("vec%0d_rdata", k), IORdData, tv[k].e_rd);
            chk($sformatf("vec%0d_in_ready", k), 16'(ExtInReady), 16'(tv[k].e_ir));
            chk($sformatf("vec%0d_out_valid", k), 16'(ExtOutValid), 16'(tv[k].e_ov));
            chk($sformatf("vec%0d_out_data", k), ExtOutData, tv[k].e_od);
        end
        step(1, 0, 0, 0, 0, 0, 0, 0);
        mq.delete();
        m_rd = '0; m_od = '0; m_ov = 0; m_udf = 0; m_ovf = 0;
        for (int i = 0; i < 600; i++) begin
            r    = $urandom_range(63) == 0;
            a    = 2'($urandom_range(3));
            rd   = $urandom_range(1);
            wr   = $urandom_range(2) == 0;
            wd   = 16'($urandom);
            iv   = $urandom_range(1);
            id   = 16'($urandom);
            ordy = $urandom_range(1);
            if (r) begin
                mq.delete();
                m_rd = '0; m_od = '0; m_ov = 0; m_udf = 0; m_ovf = 0;
            end else begin
                ir = mq.size() != DEPTH;
                if (rd) begin
                    case (a)
                        2'd0: m_rd = mq.size() != 0 ? mq[0] : 16'h0000;
                        2'd1: m_rd = m_od;
                        2'd2: m_rd = {12'b0, m_ovf, m_udf, m_ov, mq.size() != 0};
                        default: m_rd = 16'(mq.size());
                    endcase
                end
                if (wr && a == 2'd2) begin
                    if (wd[2]) m_udf = 0;
                    if (wd[3]) m_ovf = 0;
                end
                if (rd && a == 2'd0) begin
                    if (mq.size() != 0) void'(mq.pop_front());
                    else m_udf = 1;
                end
                if (iv && ir) mq.push_back(id);
                if (wr && a == 2'd1) begin
                    if (!m_ov || ordy) begin
                        m_od = wd;
                        m_ov = 1;
                    end else begin
                        m_ovf = 1;
                    end
                end else if (m_ov && ordy) begin
                    m_ov = 0;
                end
            end
            step(r, a, rd, wr, wd, iv, id, ordy);
            chk("rand_rdata", IORdData, m_rd);
            chk("rand_in_ready", 16'(ExtInReady), 16'(mq.size() != DEPTH));
            chk("rand_out_valid", 16'(ExtOutValid), 16'(m_ov));
            chk("rand_out_data", ExtOutData, m_od);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
